// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmitter and receiver: channel and
// receiver state encodings.
package i2s_pkg;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_e;

    typedef enum logic {
        ST_SYNC    = 1'b0,
        ST_RECEIVE = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_receiver_sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: samples BCLK/LRCLK/SDATA in the clk domain and
// delivers left-justified left/right words with one-cycle valid pulses.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_SYNC    | waiting for an LRCLK boundary; nothing shifted or committed
// ST_RECEIVE | shifting slot bits; every boundary commits the finished word
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATASIZE   = 12,
    parameter int SYNCSTAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                BCLK,
    input  logic                LRCLK,
    input  logic                SDATA,
    input  logic                enable,
    output logic [DATASIZE-1:0] leftAudio,
    output logic [DATASIZE-1:0] rightAudio,
    output logic                leftValid,
    output logic                rightValid,
    output logic                shortSlot
);

    localparam int              CNTW     = $clog2(DATASIZE + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DATASIZE);

    logic                bclk_s;
    logic                lr_s;
    logic                sd_s;
    logic                bclk_prev;
    logic                ws_prev;
    logic                edge_det;
    logic                boundary;

    i2s_state_e          state;
    i2s_state_e          state_nxt;
    logic                rx_edge;
    logic                enter_rx;
    logic                commit;

    logic [CNTW-1:0]     bit_cnt;
    logic [DATASIZE-1:0] shift_reg;
    logic                take_bit;
    logic [CNTW-1:0]     cnt_nxt;
    logic [DATASIZE-1:0] shift_nxt;
    logic [DATASIZE-1:0] word_just;

    logic                commit_pend;
    i2s_chan_e           commit_ch;
    logic                commit_short;
    logic [DATASIZE-1:0] commit_word;

    sync_ff #(.DEPTH(SYNCSTAGES)) u_sync_bclk (.clk(clk), .rst(rst), .d(BCLK),  .q(bclk_s));
    sync_ff #(.DEPTH(SYNCSTAGES)) u_sync_lr   (.clk(clk), .rst(rst), .d(LRCLK), .q(lr_s));
    sync_ff #(.DEPTH(SYNCSTAGES)) u_sync_sd   (.clk(clk), .rst(rst), .d(SDATA), .q(sd_s));

    assign edge_det = bclk_s & ~bclk_prev;
    assign boundary = edge_det & (lr_s != ws_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_SYNC;
        end else if ((state == ST_SYNC) && boundary) begin
            state_nxt = ST_RECEIVE;
        end
    end

    always_comb begin
        rx_edge  = 1'b0;
        enter_rx = 1'b0;
        case (state)
            ST_SYNC:    enter_rx = enable & boundary;
            ST_RECEIVE: rx_edge  = enable & edge_det;
            default:    ;
        endcase
    end

    assign commit = rx_edge & boundary;

    // The boundary bit is the previous word's LSB, so it is folded in before commit.
    always_comb begin
        take_bit  = (bit_cnt < FULL_CNT);
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        if (take_bit) begin
            shift_nxt = {shift_reg[DATASIZE-2:0], sd_s};
            cnt_nxt   = bit_cnt + 1'b1;
        end
        word_just = shift_nxt << (FULL_CNT - cnt_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_prev    <= 1'b0;
            ws_prev      <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            commit_pend  <= 1'b0;
            commit_ch    <= LEFT;
            commit_short <= 1'b0;
            commit_word  <= '0;
        end else begin
            bclk_prev   <= bclk_s;
            commit_pend <= 1'b0;
            if (edge_det) begin
                ws_prev <= lr_s;
            end
            if (!enable || enter_rx) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (rx_edge) begin
                if (commit) begin
                    commit_pend  <= 1'b1;
                    commit_ch    <= i2s_chan_e'(ws_prev);
                    commit_short <= (cnt_nxt != FULL_CNT);
                    commit_word  <= word_just;
                    bit_cnt      <= '0;
                    shift_reg    <= '0;
                end else begin
                    bit_cnt   <= cnt_nxt;
                    shift_reg <= shift_nxt;
                end
            end
        end
    end

    // A commit still in flight when enable drops is dropped with the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leftAudio  <= '0;
            rightAudio <= '0;
            leftValid  <= 1'b0;
            rightValid <= 1'b0;
            shortSlot  <= 1'b0;
        end else begin
            leftValid  <= 1'b0;
            rightValid <= 1'b0;
            shortSlot  <= 1'b0;
            if (commit_pend && enable) begin
                shortSlot <= commit_short;
                if (commit_ch == RIGHT) begin
                    rightAudio <= commit_word;
                    rightValid <= 1'b1;
                end else begin
                    leftAudio <= commit_word;
                    leftValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomized bench for i2s_receiver: an I2S stream is played on the pins and a
// slot-level model predicts every committed word.
module tb_i2s_receiver;

    localparam int DATASIZE   = 12;
    localparam int SYNCSTAGES = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                BCLK = 1'b0;
    logic                LRCLK = 1'b0;
    logic                SDATA = 1'b0;
    logic                enable = 1'b1;
    logic [DATASIZE-1:0] leftAudio;
    logic [DATASIZE-1:0] rightAudio;
    logic                leftValid;
    logic                rightValid;
    logic                shortSlot;

    i2s_receiver #(.DATASIZE(DATASIZE), .SYNCSTAGES(SYNCSTAGES)) dut (
        .clk(clk), .rst(rst), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA),
        .enable(enable), .leftAudio(leftAudio), .rightAudio(rightAudio),
        .leftValid(leftValid), .rightValid(rightValid), .shortSlot(shortSlot)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                  ch;
        logic [DATASIZE-1:0] word;
        bit                  short_w;
    } commit_t;

    int checks = 0;
    int errors = 0;

    commit_t             exp_q[$];
    bit                  m_rx;
    bit                  m_ws;
    bit                  m_bits[$];
    logic [DATASIZE-1:0] exp_l;
    logic [DATASIZE-1:0] exp_r;

    int                  n_left = 0;
    int                  n_right = 0;
    logic [DATASIZE-1:0] obs_l = '0;
    logic [DATASIZE-1:0] obs_r = '0;
    bit                  obs_ls = 1'b0;
    bit                  obs_rs = 1'b0;
    int                  last_lat = 0;

    bit s_ws[$];
    bit s_sd[$];
    bit s_en[$];
    bit carry = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rx = 1'b0;
        m_ws = 1'b0;
        m_bits.delete();
        exp_q.delete();
        exp_l = '0;
        exp_r = '0;
    endtask

    // One BCLK rising edge as seen on the pins.
    task automatic model_edge(bit ws, bit sd, bit en);
        bit      bnd;
        commit_t c;
        bnd = (ws != m_ws);
        if (!en) begin
            m_rx = 1'b0;
            m_bits.delete();
        end else if (!m_rx) begin
            if (bnd) begin
                m_rx = 1'b1;
                m_bits.delete();
            end
        end else begin
            if (m_bits.size() < DATASIZE) m_bits.push_back(sd);
            if (bnd) begin
                c.ch = m_ws;
                c.word = '0;
                foreach (m_bits[i]) c.word[DATASIZE-1-i] = m_bits[i];
                c.short_w = (m_bits.size() < DATASIZE);
                exp_q.push_back(c);
                m_bits.delete();
            end
        end
        m_ws = ws;
    endtask

    always @(negedge clk) begin : compare
        commit_t c;
        check("both_valid", {31'b0, leftValid & rightValid}, 32'h0);
        if (!enable) check("valid_while_disabled", {31'b0, leftValid | rightValid}, 32'h0);
        if (leftValid || rightValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'b0, leftValid | rightValid}, 32'h0);
            end else begin
                c = exp_q.pop_front();
                check("valid_channel", {31'b0, rightValid}, {31'b0, c.ch});
                check("short_slot", {31'b0, shortSlot}, {31'b0, c.short_w});
                if (c.ch) exp_r = c.word;
                else      exp_l = c.word;
            end
            if (leftValid) begin
                n_left++;
                obs_l  = leftAudio;
                obs_ls = shortSlot;
            end
            if (rightValid) begin
                n_right++;
                obs_r  = rightAudio;
                obs_rs = shortSlot;
            end
        end else begin
            check("short_without_valid", {31'b0, shortSlot}, 32'h0);
        end
        check("left_audio", 32'(leftAudio), 32'(exp_l));
        check("right_audio", 32'(rightAudio), 32'(exp_r));
    end

    // Slot bit k is carried in BCLK k+1; the slot's last bit rides the next slot's first BCLK.
    task automatic push_slot(bit ws, logic [63:0] seq, int len);
        for (int k = 0; k < len; k++) begin
            s_ws.push_back(ws);
            if (k == 0) s_sd.push_back(carry);
            else        s_sd.push_back(seq[64-k]);
            s_en.push_back(1'b1);
        end
        carry = seq[64-len];
    endtask

    // Starts and ends on a clk falling edge; BCLK = clk/8.
    task automatic bclk_period(bit ws, bit sd, bit en);
        BCLK  = 1'b0;
        LRCLK = ws;
        SDATA = sd;
        @(negedge clk);
        enable = en;
        repeat (3) @(negedge clk);
        BCLK = 1'b1;
        model_edge(ws, sd, enable);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (leftValid || rightValid) last_lat = j;
        end
    endtask

    task automatic play_n(int n);
        bit ws, sd, en;
        for (int i = 0; i < n; i++) begin
            if (s_ws.size() == 0) break;
            ws = s_ws.pop_front();
            sd = s_sd.pop_front();
            en = s_en.pop_front();
            bclk_period(ws, sd, en);
        end
    endtask

    task automatic play_all();
        play_n(s_ws.size());
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        int idx;
        int len;
        int base;
        bit ws;
        model_reset();
        repeat (5) @(negedge clk);
        check("reset_left", 32'(leftAudio), 32'h0);
        check("reset_right", 32'(rightAudio), 32'h0);
        check("reset_valid", {30'b0, leftValid, rightValid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal 12-bit frames; the first left word after reset is never delivered.
        for (int f = 0; f < 3; f++) begin
            push_slot(1'b0, {12'hA5C, 52'd0}, 12);
            push_slot(1'b1, {12'h3F1, 52'd0}, 12);
        end
        play_all();
        check("nominal_left_count", n_left, 2);
        check("nominal_right_count", n_right, 2);
        check("nominal_left_word", 32'(obs_l), 32'hA5C);
        check("nominal_right_word", 32'(obs_r), 32'h3F1);
        check("latency_clk", last_lat, SYNCSTAGES + 2);

        // Long 16-BCLK slots: extra bits dropped.
        for (int f = 0; f < 2; f++) begin
            push_slot(1'b0, {12'h123, 4'hF, 48'd0}, 16);
            push_slot(1'b1, {12'h3F1, 4'hF, 48'd0}, 16);
        end
        play_all();
        check("long_slot_word", 32'(obs_l), 32'h123);
        check("long_slot_short", {31'b0, obs_ls}, 32'h0);

        // Short 8-BCLK slots: left-justified with shortSlot.
        for (int f = 0; f < 2; f++) begin
            push_slot(1'b0, {8'b10110011, 56'd0}, 8);
            push_slot(1'b1, {$urandom, $urandom}, 8);
        end
        play_all();
        check("short_slot_word", 32'(obs_l), 32'hB30);
        check("short_slot_flag", {31'b0, obs_ls}, 32'h1);

        // Enable dropped for 3 BCLK mid left word.
        base = n_left;
        idx = s_ws.size();
        push_slot(1'b0, {12'h6C3, 52'd0}, 12);
        for (int d = 4; d < 7; d++) s_en[idx + d] = 1'b0;
        push_slot(1'b1, {$urandom, $urandom}, 12);
        push_slot(1'b0, {12'h5A7, 52'd0}, 12);
        push_slot(1'b1, {$urandom, $urandom}, 12);
        play_all();
        check("enable_drop_left_count", n_left - base, 1);
        check("enable_drop_left_word", 32'(obs_l), 32'h5A7);

        // Reset pulsed mid right word.
        push_slot(1'b0, {$urandom, $urandom}, 12);
        push_slot(1'b1, {12'hC3A, 52'd0}, 12);
        play_n(18);
        BCLK = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_left_async", 32'(leftAudio), 32'h0);
        check("rst_right_async", 32'(rightAudio), 32'h0);
        check("rst_valid_async", {29'b0, leftValid, rightValid, shortSlot}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = n_left + n_right;
        play_all();
        check("post_rst_no_valid", n_left + n_right - base, 0);
        push_slot(1'b0, {12'h2B4, 52'd0}, 12);
        push_slot(1'b1, {$urandom, $urandom}, 12);
        play_all();
        check("post_rst_valid_count", n_left + n_right - base, 2);
        check("post_rst_right_word", 32'(obs_r), 32'hE80);
        check("post_rst_right_short", {31'b0, obs_rs}, 32'h1);
        check("post_rst_left_word", 32'(obs_l), 32'h2B4);

        // Random slot lengths, data and enable drops.
        ws = 1'b0;
        for (int s = 0; s < 40; s++) begin
            len = $urandom_range(6, 20);
            idx = s_ws.size();
            push_slot(ws, {$urandom, $urandom}, len);
            if ($urandom_range(0, 7) == 0) begin
                int pos = $urandom_range(1, len - 2);
                int dur = $urandom_range(1, 3);
                for (int d = 0; d < dur; d++) s_en[idx + pos + d] = 1'b0;
            end
            ws = ~ws;
        end
        push_slot(ws, {$urandom, $urandom}, 12);
        play_all();
        repeat (10) @(negedge clk);
        check("pending_commits", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
